ldst_issue_queue: RTL
=====================

# ldst_issue_queue

Buffers decoded DS-format load/store micro-ops between the DS-format decoder and the load/store unit. It accepts the decoder's registered outputs and filters for the load/store functional-unit code. It sign-extends the 14-bit DS immediate to a 64-bit byte displacement and presents entries in order through a valid/ready handshake. Back-pressure reaches the decoder through `stall_o`, early enough to absorb the decoder's one in-flight result.

## Interface
Parameters:
- `regWidth`, 5, register address width.
- `immWidth`, 14, DS immediate width.
- `depth`, 4, queue entries; must be a power of two, ≥ 2.
- `ptrWidth`, 2, log2(`depth`).
- `LdStUnitCode`, 2, functional-unit code accepted into the queue.

Ports:
- `clock_i`  in  1  clock; all state changes on the rising edge.
- `resetn_i`  in  1  reset; synchronous, active-low.
- `enable_i`  in  1  decoder result valid this cycle.
- `reg1_i`  in  `regWidth`  RT/RS address.
- `reg2_i`  in  `regWidth`  RA address.
- `reg2ValOrZero_i`  in  1  RA=0 means literal zero.
- `imm_i`  in  [0:`immWidth`-1]  DS field, bits 16:29 of the instruction.
- `functionalUnitCode_i`  in  3  destination unit.
- `stall_o`  out  1  decoder must hold.
- `valid_o`  out  1  head entry valid.
- `ready_i`  in  1  load/store unit takes the head entry.
- `reg1_o`, `reg2_o`  out  `regWidth`  head register addresses.
- `reg2ValOrZero_o`  out  1  head flag.
- `disp_o`  out  [0:63]  sign-extended displacement of the head entry.
- `count_o`  out  `ptrWidth`+1  occupancy.
- `dropCount_o`  out  8  saturating count of discarded inputs.

## Operation
- Push condition: `enable_i`=1 and `functionalUnitCode_i`==`LdStUnitCode` and (`count_o`<`depth` or a pop in the same cycle).
- Pop condition: `valid_o`=1 and `ready_i`=1.
- `valid_o` = (`count_o` != 0).
- Drop cases: a non-matching unit code with `enable_i`=1 is discarded, and `dropCount_o` increments. `enable_i`=1 with a matching code while full and with no pop is also discarded, and `dropCount_o` increments.
- `dropCount_o` saturates at 255.
- Displacement:
  - `disp_o` = 48 copies of `imm[0]`, then `imm[0:13]`, then 2'b00.
  - Bit 0 is the MSB (big-endian numbering).
  - The displacement is computed at push time and stored as 64 bits.
- Storage is a circular buffer with `ptrWidth`-bit read and write pointers.
  - Pointers wrap from `depth`-1 to 0.
  - Full and empty are distinguished by `count_o`, not by the pointers.
- Simultaneous push and pop:
  - `count_o` is unchanged.
  - Both pointers advance.
  - This is legal when full and when at `count_o`=1.
- `stall_o` = (`count_o` ≥ `depth`-1). This leaves one slot for the decoder result already in flight when the stall is seen.
- Output fields (`reg1_o`, `reg2_o`, `reg2ValOrZero_o`, `disp_o`) are don't-care while `valid_o`=0. The bench must not check them then.

## Timing
- Reset (`resetn_i`=0 at a rising edge) drives:
  - `count_o`=0, `valid_o`=0, `stall_o`=0, `dropCount_o`=0.
  - Both pointers 0, and data outputs 0.
- Reset overrides a push and a pop in the same cycle.
- Reset in mid-operation discards all entries.
- Latency: an entry pushed at edge N is visible on `valid_o` and the data outputs after edge N (registered), ready for a pop at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- `stall_o` is combinational from `count_o`, so it is registered-state-only.
- Outputs never depend combinationally on `enable_i` or `ready_i`, except in the bypass configuration.

## Configuration
- `LDST_QUEUE_BYPASS_EN` defined:
  - When `count_o`=0 and a matching `enable_i` arrives, `valid_o` and the data outputs reflect the input combinationally in the same cycle.
  - If `ready_i`=1 in that cycle, the entry is consumed and never stored; `count_o` stays 0.
  - Otherwise it is stored as a normal push.
- Undefined: no bypass. Minimum latency is one cycle, as in Timing.

## Test plan
- Reset, then push `imm_i`=14'h0001, `reg1_i`=3, `reg2_i`=4 with `ready_i`=0. Next cycle: `valid_o`=1, `disp_o`=64'h0000_0000_0000_0004, `count_o`=1.
- Sign extension:
  - `imm_i`=14'h3FFF gives `disp_o`=64'hFFFF_FFFF_FFFF_FFFC.
  - `imm_i`=14'h2000 gives 64'hFFFF_FFFF_FFFF_8000.
- Fill with `ready_i`=0:
  - `stall_o` rises when `count_o`=3.
  - A 5th push is dropped; `count_o`=4 and `dropCount_o`=1.
  - Drain in order and check FIFO order across the pointer wrap.
- When full, push and pop in the same cycle: `count_o` stays 4, the popped entry is the oldest, and the new entry emerges 4 pops later.
- Input with `functionalUnitCode_i`=0, `enable_i`=1, 300 times: no push, and `dropCount_o` saturates at 255.
- Reset asserted with `count_o`=3 and a push pending: the next cycle shows `count_o`=0, `valid_o`=0, `stall_o`=0, and the pending push is lost.

Source files
------------

// File: rtl/ldst_issue_queue.sv
// In-order issue queue for DS-format load/store micro-ops with sign-extended byte displacement.
// Optional same-cycle bypass of an empty queue: define LDST_QUEUE_BYPASS_EN.
module ldst_issue_queue #(
  parameter int unsigned regWidth     = 5,
  parameter int unsigned immWidth     = 14,
  parameter int unsigned depth        = 4,
  parameter int unsigned ptrWidth     = 2,
  parameter logic [2:0]  LdStUnitCode = 3'd2
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic                  enable_i,
  input  logic [regWidth-1:0]   reg1_i,
  input  logic [regWidth-1:0]   reg2_i,
  input  logic                  reg2ValOrZero_i,
  input  logic [0:immWidth-1]   imm_i,
  input  logic [2:0]            functionalUnitCode_i,
  output logic                  stall_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [regWidth-1:0]   reg1_o,
  output logic [regWidth-1:0]   reg2_o,
  output logic                  reg2ValOrZero_o,
  output logic [0:63]           disp_o,
  output logic [ptrWidth:0]     count_o,
  output logic [7:0]            dropCount_o
);

  localparam int unsigned CntW  = ptrWidth + 1;
  localparam int unsigned DispW = 64;
  localparam int unsigned ExtW  = DispW - immWidth - 2;

  typedef struct packed {
    logic [regWidth-1:0] reg1;
    logic [regWidth-1:0] reg2;
    logic                zero;
    logic [DispW-1:0]    disp;
  } entry_t;

  entry_t              mem_q [depth];
  entry_t              mem_d [depth];
  logic [ptrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [7:0]          drop_q, drop_d;

  entry_t     in_entry_c;
  entry_t     head_c;
  logic [0:DispW-1] disp_c;
  logic       match_c;
  logic       full_c;
  logic       byp_c;
  logic       valid_c;
  logic       pop_c;
  logic       pop_stored_c;
  logic       accept_c;
  logic       push_c;
  logic       drop_c;

  // Bypass only applies to a matching op arriving at an empty queue.
`ifdef LDST_QUEUE_BYPASS_EN
  assign byp_c = match_c && (count_q == '0);
`else
  assign byp_c = 1'b0;
`endif

  // Handshake, displacement formation and next-state computation.
  always_comb begin
    disp_c       = {{ExtW{imm_i[0]}}, imm_i, 2'b00};
    in_entry_c   = '{reg1: reg1_i, reg2: reg2_i, zero: reg2ValOrZero_i, disp: disp_c};
    match_c      = enable_i && (functionalUnitCode_i == LdStUnitCode);
    full_c       = (count_q == CntW'(depth));
    valid_c      = (count_q != '0) || byp_c;
    head_c       = byp_c ? in_entry_c : mem_q[rd_ptr_q];
    pop_c        = valid_c && ready_i;
    pop_stored_c = pop_c && !byp_c;
    accept_c     = match_c && (!full_c || pop_c);
    push_c       = accept_c && !(byp_c && ready_i);
    drop_c       = enable_i && !accept_c;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push_c) - CntW'(pop_stored_c);
    drop_d   = drop_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = in_entry_c;
      wr_ptr_d        = wr_ptr_q + ptrWidth'(1);
    end
    if (pop_stored_c) begin
      rd_ptr_d = rd_ptr_q + ptrWidth'(1);
    end
    if (drop_c && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < int'(depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign valid_o         = valid_c;
  assign stall_o         = (count_q >= CntW'(depth - 1));
  assign reg1_o          = head_c.reg1;
  assign reg2_o          = head_c.reg2;
  assign reg2ValOrZero_o = head_c.zero;
  assign disp_o          = head_c.disp;
  assign count_o         = count_q;
  assign dropCount_o     = drop_q;

endmodule
